sensor_scan_mux: RTL and testbench
==================================

SENSOR_SCAN_MUX -- requirements
Module: sensor_scan_mux

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of sensor channels, 2..16.
REQ-002 SHALL have parameter DATA_W, default 8: width of each channel sample.
REQ-003 SHALL have parameter AVG_LOG2, default 2: each result averages 2^AVG_LOG2 samples, 0..4.
REQ-004 SHALL have parameter SETTLE, default 4: cycles waited after enabling a channel before sampling, 1..255.
REQ-005 SHALL have port clk, input, 1: the single clock. Reset is synchronous and active-low, on rst_n.
REQ-006 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-007 SHALL have port ch_data_i, input, NUM_CH*DATA_W: channel k occupies bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port start_i, input, 1: level, sampled in IDLE to begin a scan.
REQ-009 SHALL have port cont_i, input, 1: continuous mode, checked in DONE.
REQ-010 SHALL have port sel_i, input, clog2(NUM_CH): readout channel select.
REQ-011 SHALL have port ch_en_o, output, NUM_CH: one-hot enable of the active sensor.
REQ-012 SHALL have port rd_data_o, output, DATA_W: stored result of channel sel_i.
REQ-013 SHALL have port busy_o, output, 1: high in any state other than IDLE.
REQ-014 SHALL have port done_o, output, 1: one-cycle pulse at scan completion.
REQ-015 SHALL have port over_o, output, 1: sticky saturation flag (see REQ-032).

Function
REQ-016 The FSM SHALL have states IDLE, SETTLE, SAMPLE, STORE and DONE; all outputs SHALL be registered.
REQ-017 In IDLE with start_i=1: ch := 0, go to SETTLE; otherwise remain in IDLE.
REQ-018 SETTLE SHALL drive ch_en_o one-hot at ch, count SETTLE cycles, then go to SAMPLE.
REQ-019 SAMPLE SHALL add channel ch into a (DATA_W+AVG_LOG2)-bit accumulator once per cycle for 2^AVG_LOG2 cycles, with no overflow possible; the accumulator is cleared on entry.
REQ-020 STORE SHALL write acc >> AVG_LOG2 (truncating) into result[ch] in one cycle. If ch == NUM_CH-1, go to DONE; otherwise ch := ch+1 and go to SETTLE.
REQ-021 DONE SHALL last one cycle with done_o=1. If cont_i=1: ch := 0, go to SETTLE; otherwise go to IDLE.
REQ-022 Per-channel latency SHALL be SETTLE + 2^AVG_LOG2 + 1 cycles. A full scan SHALL take NUM_CH times that, plus 1 cycle for DONE.
REQ-023 ch_en_o SHALL be all-zero in IDLE and DONE, and exactly one-hot in SETTLE, SAMPLE and STORE.
REQ-024 start_i asserted while busy_o=1 SHALL be ignored.
REQ-025 rd_data_o SHALL be result[sel_i] registered with 1-cycle latency. sel_i >= NUM_CH SHALL return 0.
REQ-026 Reading a channel during its own STORE cycle SHALL return the old value; the new value appears on the following cycle.
REQ-027 Results SHALL persist across scans until overwritten; a channel not yet rescanned keeps its previous value.

Reset
REQ-028 rst_n=0 at a clk edge SHALL force: state IDLE, ch=0, accumulator=0, all result[] = 0, ch_en_o=0, rd_data_o=0, busy_o=0, done_o=0, over_o=0.
REQ-029 Reset mid-scan SHALL abort with no partial STORE; the first cycle after reset SHALL be IDLE.

Configuration
REQ-030 Macro SENSOR_SCAN_OVERRANGE_EN SHALL select the saturation detector.
REQ-031 Without SENSOR_SCAN_OVERRANGE_EN, over_o SHALL be constant 0 and no detector logic SHALL be built.
REQ-032 With SENSOR_SCAN_OVERRANGE_EN, over_o SHALL set when any SAMPLE-cycle input equals all-ones. It SHALL hold until rst_n or the next IDLE->SETTLE transition, and SHALL NOT be cleared by a cont_i restart.

Structure
REQ-033 A shared package sensor_scan_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-034 One sub-module, sensor_scan_avg (accumulator plus shift), SHALL be instantiated once.

Verification
(Directed scenarios; defaults NUM_CH=4, DATA_W=8, AVG_LOG2=2, SETTLE=4.)
REQ-035 Static channels {0x10, 0x20, 0x30, 0x40}, start_i pulse -> done_o high exactly 37 cycles after the start edge; sel_i=0..3 reads 0x10, 0x20, 0x30, 0x40.
REQ-036 Channel 1 samples 0x01, 0x02, 0x03, 0x05 during SAMPLE -> result[1] = 0x02 (11 >> 2).
REQ-037 cont_i=1 held -> done_o pulses every 37 cycles and ch_en_o never shows more than one bit set. After cont_i drops, the scan returns to IDLE after the next DONE.
REQ-038 rst_n=0 during channel-2 SAMPLE -> the next cycle is IDLE, all reads return 0x00, and busy_o=0.
REQ-039 start_i held high through a scan -> no second scan begins before DONE, and a new scan starts on the IDLE cycle after DONE.
REQ-040 With SENSOR_SCAN_OVERRANGE_EN, channel 3 = 0xFF -> over_o=1 after that channel's first SAMPLE cycle; over_o stays set until the next start. Without the macro, over_o=0.

Source files
------------

// File: rtl/sensor_scan_pkg.sv
// sensor_scan_pkg: FSM state encoding and default configuration shared by the scan mux and its averager
package sensor_scan_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_STORE,
    S_DONE
  } state_t;
  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_AVG_LOG2 = 2;
  localparam int DEF_SETTLE   = 4;
endpackage

// File: rtl/sensor_scan_avg.sv
// sensor_scan_avg: sample accumulator whose output is the truncated mean of 2^AVG_LOG2 samples
module sensor_scan_avg
  import sensor_scan_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] avg
);
  localparam int AW = DATA_W + AVG_LOG2;
  logic [AW-1:0] acc;
  // AVG_LOG2 guard bits make overflow impossible over a full sample window
  always_ff @(posedge clk)
    acc <= !rst_n ? '0 : clr ? '0 : en ? acc + AW'(din) : acc;
  assign avg = acc[AW-1:AVG_LOG2];
endmodule

// File: rtl/sensor_scan_mux.sv
// sensor_scan_mux: sequential sensor scanner with settle/average/store per channel; SENSOR_SCAN_OVERRANGE_EN adds a sticky saturation flag
module sensor_scan_mux
  import sensor_scan_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int AVG_LOG2 = DEF_AVG_LOG2,
  parameter int SETTLE   = DEF_SETTLE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data_i,
  input  logic                       start_i,
  input  logic                       cont_i,
  input  logic [$clog2(NUM_CH)-1:0]  sel_i,
  output logic [NUM_CH-1:0]          ch_en_o,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       over_o
);
  localparam int SW = $clog2(NUM_CH);
  localparam logic [SW-1:0] LAST = SW'(NUM_CH - 1);
  localparam logic [SW:0] NCH = (SW+1)'(NUM_CH);
  localparam logic [7:0] SET_LAST = 8'(SETTLE - 1);
  localparam logic [7:0] SMP_LAST = 8'((1 << AVG_LOG2) - 1);
  localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);
  state_t state, state_n;
  logic [SW-1:0] ch, ch_n;
  logic [7:0] cnt, cnt_n;
  logic [NUM_CH-1:0] ch_en_n;
  logic busy_n, done_n;
  logic [DATA_W-1:0] chan [NUM_CH];
  logic [DATA_W-1:0] result [NUM_CH];
  logic [DATA_W-1:0] din, avg;
  genvar k;
  for (k = 0; k < NUM_CH; k++) begin : g_chan
    assign chan[k] = ch_data_i[k*DATA_W +: DATA_W];
  end
  assign din = chan[ch];
  // state, channel index and phase counter
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= S_IDLE;
      ch    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ch    <= ch_n;
      cnt   <= cnt_n;
    end
  // next-state sequencing: settle, sample window, store, advance channel
  always_comb begin
    state_n = state;
    ch_n    = ch;
    cnt_n   = cnt;
    case (state)
      S_IDLE:
        if (start_i) begin
          state_n = S_SETTLE;
          ch_n    = '0;
          cnt_n   = '0;
        end
      S_SETTLE:
        if (cnt == SET_LAST) begin
          state_n = S_SAMPLE;
          cnt_n   = '0;
        end else cnt_n = cnt + 8'd1;
      S_SAMPLE:
        if (cnt == SMP_LAST) begin
          state_n = S_STORE;
          cnt_n   = '0;
        end else cnt_n = cnt + 8'd1;
      S_STORE:
        if (ch == LAST) state_n = S_DONE;
        else begin
          state_n = S_SETTLE;
          ch_n    = ch + SW'(1);
        end
      S_DONE: begin
        state_n = cont_i ? S_SETTLE : S_IDLE;
        ch_n    = '0;
      end
      default: state_n = S_IDLE;
    endcase
  end
  // outputs derived from the upcoming state so the registered copies line up with it
  always_comb begin
    busy_n  = state_n != S_IDLE;
    done_n  = state_n == S_DONE;
    ch_en_n = (state_n == S_SETTLE || state_n == S_SAMPLE || state_n == S_STORE) ? ONE << ch_n : '0;
  end
  // registered control outputs
  always_ff @(posedge clk)
    if (!rst_n) begin
      ch_en_o <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      ch_en_o <= ch_en_n;
      busy_o  <= busy_n;
      done_o  <= done_n;
    end
  sensor_scan_avg #(
    .DATA_W  (DATA_W),
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state == S_SETTLE),
    .en   (state == S_SAMPLE),
    .din  (din),
    .avg  (avg)
  );
  // result store; reset wins so an aborted scan never commits a partial average
  always_ff @(posedge clk)
    if (!rst_n) for (int i = 0; i < NUM_CH; i++) result[i] <= '0;
    else if (state == S_STORE) result[ch] <= avg;
  // readout sees the pre-store value during a store cycle; out-of-range selects read zero
  always_ff @(posedge clk)
    rd_data_o <= !rst_n ? '0 : ({1'b0, sel_i} < NCH) ? result[sel_i] : '0;
`ifdef SENSOR_SCAN_OVERRANGE_EN
  // sticky saturation flag, cleared only by reset or a fresh start from idle
  always_ff @(posedge clk)
    over_o <= !rst_n ? 1'b0 : (state == S_IDLE && start_i) ? 1'b0 : (state == S_SAMPLE && din == '1) ? 1'b1 : over_o;
`else
  assign over_o = 1'b0;
`endif
endmodule

// File: tb/tb_sensor_scan_mux.sv
// tb_sensor_scan_mux: directed checks of scan timing, averaging, readout, continuous mode, reset abort and over-range flag
module tb_sensor_scan_mux;
  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, cont_i = 1'b0;
  logic [31:0] ch_data_i = '0;
  logic [1:0] sel_i = '0;
  logic [3:0] ch_en_o;
  logic [7:0] rd_data_o;
  logic busy_o, done_o, over_o;
  int checks = 0, errors = 0, onehot_bad = 0, n;
`ifdef SENSOR_SCAN_OVERRANGE_EN
  localparam logic OV = 1'b1;
`else
  localparam logic OV = 1'b0;
`endif
  sensor_scan_mux #(
    .NUM_CH(4), .DATA_W(8), .AVG_LOG2(2), .SETTLE(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ch_data_i(ch_data_i), .start_i(start_i), .cont_i(cont_i),
    .sel_i(sel_i), .ch_en_o(ch_en_o), .rd_data_o(rd_data_o), .busy_o(busy_o),
    .done_o(done_o), .over_o(over_o)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if ($countones(ch_en_o) > 1) onehot_bad++;
  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_done(output int k);
    k = 0;
    do begin
      step(1);
      k++;
    end while (!done_o && k < 100);
  endtask
  task automatic rd(input logic [1:0] s, input logic [7:0] exp, input string tag);
    sel_i = s;
    step(1);
    chk(tag, rd_data_o, exp);
  endtask
  initial begin
    step(2);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ch_en", ch_en_o, 0);
    chk("rst_rd", rd_data_o, 0);
    chk("rst_over", over_o, 0);
    rst_n = 1'b1;
    ch_data_i = 32'h40302010;
    step(1);
    chk("idle_busy", busy_o, 0);
    // basic scan: cycle 1 follows the start edge, DONE is cycle 37
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    chk("scan_busy", busy_o, 1);
    chk("scan_ch0_en", ch_en_o, 4'b0001);
    step(9);
    chk("scan_ch1_en", ch_en_o, 4'b0010);
    step(26);
    chk("scan_pre_done", done_o, 0);
    chk("scan_ch3_en", ch_en_o, 4'b1000);
    step(1);
    chk("scan_done", done_o, 1);
    chk("scan_done_en", ch_en_o, 0);
    chk("scan_done_busy", busy_o, 1);
    step(1);
    chk("scan_done_pulse", done_o, 0);
    chk("scan_idle_busy", busy_o, 0);
    rd(0, 8'h10, "rd_ch0");
    rd(1, 8'h20, "rd_ch1");
    rd(2, 8'h30, "rd_ch2");
    rd(3, 8'h40, "rd_ch3");
    // channel 1 averages 1,2,3,5 -> 11>>2 = 2; read during its store returns the old value
    sel_i = 2'd1;
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    step(13);
    ch_data_i[15:8] = 8'h01;
    step(1);
    ch_data_i[15:8] = 8'h02;
    step(1);
    ch_data_i[15:8] = 8'h03;
    step(1);
    ch_data_i[15:8] = 8'h05;
    step(1);
    chk("store_cycle_rd", rd_data_o, 8'h20);
    step(1);
    chk("store_old_rd", rd_data_o, 8'h20);
    step(1);
    chk("avg_ch1", rd_data_o, 8'h02);
    wait_done(n);
    chk("avg_scan_len", n, 17);
    rd(2, 8'h30, "avg_rd_ch2");
    // start held high: no restart before DONE, restart on the IDLE cycle after it
    start_i = 1'b1;
    step(1);
    wait_done(n);
    chk("held_len", n, 36);
    step(1);
    chk("held_idle", busy_o, 0);
    step(1);
    chk("held_restart", busy_o, 1);
    chk("held_restart_en", ch_en_o, 4'b0001);
    // continuous mode: DONE every 37 cycles, stops after the DONE following cont drop
    start_i = 1'b0;
    cont_i = 1'b1;
    wait_done(n);
    chk("cont_first", n, 36);
    wait_done(n);
    chk("cont_period1", n, 37);
    wait_done(n);
    chk("cont_period2", n, 37);
    step(1);
    chk("cont_restart", busy_o, 1);
    cont_i = 1'b0;
    wait_done(n);
    chk("cont_last", n, 36);
    step(1);
    chk("cont_stop_idle", busy_o, 0);
    step(3);
    chk("cont_stay_idle", busy_o, 0);
    chk("onehot", onehot_bad, 0);
    // reset during channel-2 sampling; channels 2/3 still hold the previous scan's results before reset
    ch_data_i = 32'h44332211;
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    step(19);
    rd(1, 8'h22, "persist_new_ch1");
    rd(3, 8'h40, "persist_old_ch3");
    step(2);
    chk("abort_pos", ch_en_o, 4'b0100);
    rst_n = 1'b0;
    step(1);
    chk("abort_busy", busy_o, 0);
    chk("abort_en", ch_en_o, 0);
    chk("abort_rd", rd_data_o, 0);
    rst_n = 1'b1;
    step(1);
    chk("abort_idle", busy_o, 0);
    rd(0, 8'h00, "abort_rd0");
    rd(1, 8'h00, "abort_rd1");
    rd(2, 8'h00, "abort_rd2");
    rd(3, 8'h00, "abort_rd3");
    // over-range on channel 3: first ch3 sample cycle is cycle 32
    ch_data_i = 32'hFF302010;
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    step(31);
    chk("ov_before", over_o, 0);
    chk("ov_pos", ch_en_o, 4'b1000);
    step(1);
    chk("ov_set", over_o, OV);
    wait_done(n);
    chk("ov_scan_len", n, 4);
    chk("ov_hold_done", over_o, OV);
    step(2);
    chk("ov_hold_idle", over_o, OV);
    rd(3, 8'hFF, "ov_rd_ch3");
    ch_data_i = 32'h40302010;
    start_i = 1'b1;
    step(1);
    start_i = 1'b0;
    chk("ov_clear", over_o, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
